// File: rtl/sprite_pkg.sv
// Shared encodings for the sprite plotter: orientation codes, FSM states and
// default screen geometry.
package sprite_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned SCREEN_W_DEF = 160;
   localparam int unsigned SCREEN_H_DEF = 120;

endpackage

// File: rtl/sprite_rotate.sv
// Maps a screen-relative pixel (r,c) and an orientation to the bit index of the
// up-orientation sprite bitmap that supplies that pixel.
module sprite_rotate
   import sprite_pkg::*;
#(
   parameter int unsigned SPRITE_N = 3,
   parameter int unsigned IDX_W    = 4
) (
   input  logic [2:0]       r,
   input  logic [2:0]       c,
   input  logic [1:0]       dir,
   output logic [IDX_W-1:0] idx_c
);

   int unsigned ri_c;
   int unsigned ci_c;
   int unsigned lin_c;

   // Rotate the source coordinate back into the unrotated bitmap.
   always_comb begin
      ri_c  = 32'(r);
      ci_c  = 32'(c);
      lin_c = ri_c * SPRITE_N + ci_c;
      case (dir)
         DIR_UP:    lin_c = ri_c * SPRITE_N + ci_c;
         DIR_RIGHT: lin_c = (SPRITE_N - 1 - ci_c) * SPRITE_N + ri_c;
         DIR_DOWN:  lin_c = (SPRITE_N - 1 - ri_c) * SPRITE_N + (SPRITE_N - 1 - ci_c);
         DIR_LEFT:  lin_c = ci_c * SPRITE_N + (SPRITE_N - 1 - ri_c);
         default:   lin_c = ri_c * SPRITE_N + ci_c;
      endcase
      idx_c = IDX_W'(lin_c);
   end

endmodule

// File: rtl/sprite_plotter.sv
// Draws a square, rotatable sprite one pixel per cycle into a VGA adapter.
// Optional build macro SPRITE_PLOTTER_ERASE_EN adds an erase input that forces
// the plotted colour to 0 while keeping the pixel set and timing.
module sprite_plotter
   import sprite_pkg::*;
#(
   parameter int unsigned SPRITE_N = 3,
   parameter int unsigned COLOUR_W = 3,
   parameter int unsigned SCREEN_W = SCREEN_W_DEF,
   parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
   input  logic                         CLOCK_50,
   input  logic                         resetN,
   input  logic                         go,
   input  logic [7:0]                   x_in,
   input  logic [6:0]                   y_in,
   input  logic [1:0]                   dir,
   input  logic [SPRITE_N*SPRITE_N-1:0] sprite_mask,
   input  logic [COLOUR_W-1:0]          colour_in,
`ifdef SPRITE_PLOTTER_ERASE_EN
   input  logic                         erase,
`endif
   output logic [7:0]                   x,
   output logic [6:0]                   y,
   output logic [COLOUR_W-1:0]          colour,
   output logic                         plot,
   output logic                         busy,
   output logic                         done
);

   localparam int unsigned NN    = SPRITE_N * SPRITE_N;
   localparam int unsigned IDX_W = $clog2(NN);
   localparam int unsigned CNT_W = 3;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     r_q, r_d, c_q, c_d;
   logic [7:0]           x0_q, x0_d;
   logic [6:0]           y0_q, y0_d;
   logic [1:0]           dir_q, dir_d;
   logic [NN-1:0]        mask_q, mask_d;
   logic [COLOUR_W-1:0]  col_q, col_d;
   logic [7:0]           x_q, x_d;
   logic [6:0]           y_q, y_d;
   logic [COLOUR_W-1:0]  colour_q, colour_d;
   logic                 plot_q, plot_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [IDX_W-1:0]     src_idx_c;
   logic [COLOUR_W-1:0]  pix_colour_c;
   logic [8:0]           x_sum_c;
   logic [7:0]           y_sum_c;
   logic                 last_c;

   sprite_rotate #(
      .SPRITE_N (SPRITE_N),
      .IDX_W    (IDX_W)
   ) u_rotate (
      .r     (r_q),
      .c     (c_q),
      .dir   (dir_q),
      .idx_c (src_idx_c)
   );

`ifdef SPRITE_PLOTTER_ERASE_EN
   logic erase_q, erase_d;

   // Erasing paints the same pixels in background colour 0.
   assign pix_colour_c = erase_q ? '0 : col_q;
`else
   assign pix_colour_c = col_q;
`endif

   // State, latched sprite and output registers.
   always_ff @(posedge CLOCK_50 or negedge resetN) begin
      if (!resetN) begin
         state_q  <= IDLE;
         r_q      <= '0;
         c_q      <= '0;
         x0_q     <= '0;
         y0_q     <= '0;
         dir_q    <= '0;
         mask_q   <= '0;
         col_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SPRITE_PLOTTER_ERASE_EN
         erase_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         c_q      <= c_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         dir_q    <= dir_d;
         mask_q   <= mask_d;
         col_q    <= col_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef SPRITE_PLOTTER_ERASE_EN
         erase_q  <= erase_d;
`endif
      end
   end

   // Next-state, scan counters, screen wrap and registered pixel outputs.
   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      c_d      = c_q;
      x0_d     = x0_q;
      y0_d     = y0_q;
      dir_d    = dir_q;
      mask_d   = mask_q;
      col_d    = col_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      plot_d   = 1'b0;
      done_d   = (state_q == DONE);
`ifdef SPRITE_PLOTTER_ERASE_EN
      erase_d  = erase_q;
`endif
      x_sum_c  = {1'b0, x0_q} + 9'(c_q);
      y_sum_c  = {1'b0, y0_q} + 8'(r_q);
      last_c   = (r_q == CNT_W'(SPRITE_N - 1)) && (c_q == CNT_W'(SPRITE_N - 1));

      case (state_q)
         IDLE: begin
            // busy_q stays high through the done pulse, so go is refused until then.
            if (go && !busy_q) begin
               state_d = SCAN;
               r_d     = '0;
               c_d     = '0;
               x0_d    = ({1'b0, x_in} >= 9'(SCREEN_W)) ? 8'(SCREEN_W - 1) : x_in;
               y0_d    = ({1'b0, y_in} >= 8'(SCREEN_H)) ? 7'(SCREEN_H - 1) : y_in;
               dir_d   = dir;
               mask_d  = sprite_mask;
               col_d   = colour_in;
`ifdef SPRITE_PLOTTER_ERASE_EN
               erase_d = erase;
`endif
            end
         end
         SCAN: begin
            x_d      = (x_sum_c >= 9'(SCREEN_W)) ? 8'(x_sum_c - 9'(SCREEN_W)) : x_sum_c[7:0];
            y_d      = (y_sum_c >= 8'(SCREEN_H)) ? 7'(y_sum_c - 8'(SCREEN_H)) : y_sum_c[6:0];
            colour_d = pix_colour_c;
            plot_d   = mask_q[src_idx_c];
            if (last_c) begin
               state_d = DONE;
            end else if (c_q == CNT_W'(SPRITE_N - 1)) begin
               c_d = '0;
               r_d = r_q + CNT_W'(1);
            end else begin
               c_d = c_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Covers the one-cycle lag of the registered pixel and done outputs.
      busy_d = (state_d != IDLE) || (state_q != IDLE);
   end

   assign x      = x_q;
   assign y      = y_q;
   assign colour = colour_q;
   assign plot   = plot_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule
